im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Writer side of the instruction memory: streams a program image into IM after
//  reset, replacing the built-in test program. Accepts bytes on a valid/ready
//  stream, packs them big-endian into 32-bit words and drives IM's write port.
//  Holds the CPU via cpu_hold while loading. Sits between the host byte link and IM.
// PARAMETERS
//  DEPTH   30  IM depth in words; must match IM memory[0:DEPTH-1]
//  CNT_W   5   width of the word index; must satisfy 2**CNT_W >= DEPTH
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        1-cycle pulse: begin a load; sampled only in IDLE
//  num_words   in   CNT_W+1  word count for this load, sampled with start
//  byte_valid  in   1        byte_data is valid
//  byte_data   in   8        stream byte
//  byte_ready  out  1        loader accepts byte this cycle
//  im_we       out  1        IM write strobe, 1 cycle per word
//  im_waddr    out  32       IM byte address, word aligned (IM indexes addr/4)
//  im_wdata    out  32       word to write
//  cpu_hold    out  1        stall PC/pipeline while 1
//  done        out  1        1-cycle pulse at end of a load
//  len_err     out  1        sticky: start with num_words > DEPTH
//  csum_err    out  1        sticky: checksum byte mismatch
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; byte_ready, im_we, cpu_hold, done,
//    len_err, csum_err = 0; im_waddr = 0; im_wdata = 0; byte/word counters and
//    the XOR accumulator = 0. IM contents are not touched by reset.
//  - A byte is accepted iff byte_valid && byte_ready on a rising edge.
//  - FSM: IDLE -> LOAD -> CHECK -> DONE -> IDLE.
//    IDLE:  byte_ready=0. On start: num_words>DEPTH -> set len_err, stay IDLE;
//           num_words==0 -> DONE; otherwise clear csum_err, zero the counters
//           and the XOR accumulator, -> LOAD. cpu_hold goes 1 on the cycle after start.
//    LOAD:  byte_ready=1. The 1st byte of a word goes to wdata[31:24] and the 4th to [7:0].
//           XOR accumulator ^= every accepted data byte. On the 4th byte of a word,
//           register im_we=1, im_waddr=word_idx*4, im_wdata=packed word (write
//           visible one cycle after the accepting edge). Then word_idx++. After word
//           num_words-1 -> CHECK.
//    CHECK: byte_ready=1. The next accepted byte is compared with the accumulator;
//           on mismatch csum_err=1. Then -> DONE.
//    DONE:  done=1 for exactly one cycle, byte_ready=0, cpu_hold=0 from the
//           next cycle; -> IDLE.
//  - cpu_hold=1 in LOAD, CHECK and DONE; 0 in IDLE.
//  - start outside IDLE is ignored. byte_valid in IDLE/DONE is not accepted.
//  - byte_valid gaps are allowed anywhere and the state holds. im_we is never high
//    two cycles in a row. Max throughput: 1 byte/cycle.
//  - Address wrap: cannot occur, because num_words<=DEPTH is enforced at start.
//  - Reset mid-load: loader returns to IDLE and the IM holds a partial image.
//    The host must restart the load. Errors are cleared only by reset
//    (len_err) or by the next valid start (csum_err).
//  - IM revision: IM gains a synchronous write port (im_we/im_waddr/im_wdata,
//    written on posedge clk). The combinational read path is unchanged.
// STRUCTURE
//  - Shared package/header: IM_DEPTH (=30), loader state encodings
//    (IDLE=2'd0, LOAD=2'd1, CHECK=2'd2, DONE=2'd3). IM and im_loader use the same
//    IM_DEPTH.
//  - One sub-module: im_word_packer (2-bit byte counter + 32-bit shift register,
//    emits word + word_valid pulse). FSM, address counter and checksum are in
//    im_loader.
// TESTING
//  1 Reset: hold rst_n=0 mid-cycle -> all outputs 0 at once (async), state IDLE.
//  2 start, num_words=2, bytes 20 08 00 20 20 09 00 37, csum 16 -> im_we at
//    addr 0 data 0x20080020, addr 4 data 0x20090037; done pulse; csum_err=0;
//    IM read of addr 4 returns 0x20090037.
//  3 Same stream with checksum byte 0x17 -> both words written, csum_err=1, done=1.
//  4 start with num_words=31 -> len_err=1, byte_ready=0, cpu_hold=0, no im_we.
//    start with num_words=0 -> done pulse, no im_we.
//  5 byte_valid toggling 1/0 random over a 30-word load -> 30 writes at addrs
//    0..116 step 4, data correct. A second start mid-load is ignored.
//  6 rst_n low after 6 bytes of a 2-word load -> IDLE, cpu_hold=0. A new full load
//    afterwards succeeds.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the IM itself.
//   IM_DEPTH   : IM depth in words; IM and im_loader must agree on it.
//   ld_state_e : loader FSM state encoding.
package im_loader_pkg;

  localparam int unsigned IM_DEPTH = 30;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/im_word_packer.sv
// Packs a byte stream big-endian into 32-bit words.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clr         : restart packing at byte 0 of a word
//   byte_en     : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word        : packed word, valid while word_valid is high
//   word_valid  : high in the cycle the 4th byte of a word is consumed
module im_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storing; the 4th is taken straight from the input.
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], byte_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word       = {sr_q, byte_data};
  assign word_valid = byte_en && (cnt_q == 2'd3) && !clr;

endmodule

// File: rtl/im_loader.sv
// Streams a program image into the instruction memory after reset.
// Bytes arrive on a valid/ready link, are packed big-endian into words and
// written through IM's synchronous write port; a trailing XOR checksum byte
// is verified. The CPU is held off while a load is in progress.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start, num_words      : begin a load of num_words words (sampled in idle)
//   byte_valid/byte_data  : input byte stream; byte_ready is the handshake
//   im_we/im_waddr/im_wdata : IM write port, one strobe per word
//   cpu_hold              : stall CPU while loading
//   done                  : one-cycle pulse at the end of a load
//   len_err, csum_err     : sticky error flags
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned DEPTH = IM_DEPTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W:0]   num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_waddr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             len_err,
  output logic             csum_err
);

  localparam logic [CNT_W:0] DepthW = (CNT_W + 1)'(DEPTH);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] last_idx_q, last_idx_d;
  logic [7:0]       csum_q, csum_d;
  logic             im_we_q, im_we_d;
  logic [31:0]      im_waddr_q, im_waddr_d;
  logic [31:0]      im_wdata_q, im_wdata_d;
  logic             len_err_q, len_err_d;
  logic             csum_err_q, csum_err_d;

  logic             accept;
  logic             load_go;
  logic [31:0]      pk_word;
  logic             pk_word_valid;

  assign byte_ready = (state_q == StLoad) || (state_q == StCheck);
  assign accept     = byte_valid && byte_ready;
  assign load_go    = (state_q == StIdle) && start && (num_words <= DepthW) && (num_words != '0);

  im_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (load_go),
    .byte_en    (accept && (state_q == StLoad)),
    .byte_data  (byte_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    csum_d     = csum_q;
    im_we_d    = 1'b0;
    im_waddr_d = im_waddr_q;
    im_wdata_d = im_wdata_q;
    len_err_d  = len_err_q;
    csum_err_d = csum_err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words > DepthW) begin
            len_err_d = 1'b1;
          end else if (num_words == '0) begin
            state_d = StDone;
          end else begin
            csum_err_d = 1'b0;
            word_idx_d = '0;
            csum_d     = '0;
            last_idx_d = CNT_W'(num_words - 1'b1);
            state_d    = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          csum_d = csum_q ^ byte_data;
          if (pk_word_valid) begin
            im_we_d    = 1'b1;
            im_waddr_d = {{(30 - CNT_W){1'b0}}, word_idx_q, 2'b00};
            im_wdata_d = pk_word;
            word_idx_d = word_idx_q + 1'b1;
            if (word_idx_q == last_idx_q) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (accept) begin
          if (byte_data != csum_q) begin
            csum_err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      last_idx_q <= '0;
      csum_q     <= '0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= '0;
      len_err_q  <= 1'b0;
      csum_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      csum_q     <= csum_d;
      im_we_q    <= im_we_d;
      im_waddr_q <= im_waddr_d;
      im_wdata_q <= im_wdata_d;
      len_err_q  <= len_err_d;
      csum_err_q <= csum_err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_waddr = im_waddr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign len_err  = len_err_q;
  assign csum_err = csum_err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of load scenarios with random
// payloads, a queue-based expected-write model and an IM image model.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W:0]   num_words = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready, im_we, cpu_hold, done, len_err, csum_err;
  logic [31:0]      im_waddr, im_wdata;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  logic prev_we = 1'b0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] im_mem[IM_DEPTH];
  logic [7:0]  stim[$];
  logic [7:0]  fixed_bytes[8];

  typedef struct {
    int nw;
    bit bad;
    bit gaps;
    bit fixed;
    bit mid_start;
    int exp_writes;
    bit exp_csum_err;
    bit exp_len_err;
  } vec_t;

  vec_t tbl[7];

  im_loader #(.DEPTH(IM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .len_err    (len_err),
    .csum_err   (csum_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && im_we) begin
        chk("we_not_back_to_back", 32'(prev_we), 32'd0);
        if (exp_addr.size() == 0) begin
          chk("unexpected_we", 32'(im_we), 32'd0);
        end else begin
          chk("we_addr", im_waddr, exp_addr.pop_front());
          chk("we_data", im_wdata, exp_data.pop_front());
        end
        if (im_waddr[31:2] < 30'(IM_DEPTH)) im_mem[im_waddr[6:2]] = im_wdata;
        writes_seen++;
      end
      prev_we = rst_n ? im_we : 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_im_waddr"}, im_waddr, 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_len_err"}, 32'(len_err), 32'd0);
    chk({tag, "_csum_err"}, 32'(csum_err), 32'd0);
  endtask

  task automatic pulse_start(input int nw);
    start = 1'b1;
    num_words = (CNT_W + 1)'(nw);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("byte_accept_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
  endtask

  // Builds the stimulus and queues the writes the IM should see.
  function automatic logic [7:0] build_model(input int nw, input bit fixed);
    logic [7:0] x = '0;
    stim.delete();
    if (fixed) foreach (fixed_bytes[i]) stim.push_back(fixed_bytes[i]);
    else for (int i = 0; i < 4 * nw; i++) stim.push_back(8'($urandom));
    foreach (stim[i]) x ^= stim[i];
    if (nw >= 1 && nw <= int'(IM_DEPTH)) begin
      for (int w = 0; w < nw; w++) begin
        exp_addr.push_back(32'(4 * w));
        exp_data.push_back({stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]});
      end
    end
    return x;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] x;
    int w0;
    x = build_model(v.nw, v.fixed);
    w0 = writes_seen;
    pulse_start(v.nw);
    if (v.nw > int'(IM_DEPTH)) begin
      chk("len_err_set", 32'(len_err), 32'd1);
      chk("len_byte_ready", 32'(byte_ready), 32'd0);
      chk("len_cpu_hold", 32'(cpu_hold), 32'd0);
      byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      chk("len_still_idle", 32'(cpu_hold), 32'd0);
    end else if (v.nw == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_hold", 32'(cpu_hold), 32'd1);
      @(negedge clk);
      chk("zero_done_end", 32'(done), 32'd0);
    end else begin
      chk("load_hold", 32'(cpu_hold), 32'd1);
      chk("load_ready", 32'(byte_ready), 32'd1);
      foreach (stim[i]) begin
        if (v.mid_start && i == 20) begin
          start = 1'b1;
          num_words = 6'd3;
        end
        send_byte(stim[i], v.gaps);
        start = 1'b0;
      end
      send_byte(v.bad ? (x ^ 8'h01) : x, v.gaps);
      chk("load_done", 32'(done), 32'd1);
      chk("load_done_hold", 32'(cpu_hold), 32'd1);
      @(negedge clk);
      chk("load_done_end", 32'(done), 32'd0);
      chk("load_hold_end", 32'(cpu_hold), 32'd0);
    end
    chk("writes", 32'(writes_seen - w0), 32'(v.exp_writes));
    chk("csum_err", 32'(csum_err), 32'(v.exp_csum_err));
    chk("len_err", 32'(len_err), 32'(v.exp_len_err));
    chk("writes_pending", 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    fixed_bytes = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    //           nw  bad gaps fix mid  wr  csum len
    tbl[0] = '{0,  0, 0, 0, 0, 0,  0, 0};
    tbl[1] = '{2,  0, 0, 1, 0, 2,  0, 0};
    tbl[2] = '{2,  1, 0, 1, 0, 2,  1, 0};
    tbl[3] = '{31, 0, 0, 0, 0, 0,  1, 1};
    tbl[4] = '{30, 0, 1, 0, 1, 30, 0, 1};
    tbl[5] = '{1,  1, 0, 0, 0, 1,  1, 1};
    tbl[6] = '{7,  0, 1, 0, 0, 7,  0, 1};

    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i]);
      if (i == 1) chk("im_read_addr4", im_mem[1], 32'h20090037);
      @(negedge clk);
    end

    // Reset in the middle of a 2-word load, after 6 bytes.
    void'(build_model(2, 1'b1));
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(stim[i], 1'b0);
    chk("partial_hold", 32'(cpu_hold), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hold", 32'(cpu_hold), 32'd0);
    chk("partial_image_word0", im_mem[0], 32'h20080020);

    v = '{2, 0, 1, 1, 0, 2, 0, 0};
    run_vec(v);
    chk("reload_word1", im_mem[1], 32'h20090037);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
